div_iter: RTL and testbench

- Multi-cycle radix-2 integer divider. It is the responder side of the EX-stage divide request (div_en / div_op / operands in, result / busy / done out).
- Serves the LoongArch DIV.W, MOD.W, DIV.WU and MOD.WU instructions.
- Holds its result until EX signals that the instruction has left the stage, so a stalled EX never restarts the divide.

---
 rtl/div_iter.sv | 203 ++++++++++++++++++++
 tb/tb_div_iter.sv | 340 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_iter.sv
// -----------------------------------------------------------------------------
// div_iter -- multi-cycle radix-2 restoring integer divider
//
// Responder side of the EX-stage divide request. Serves DIV.W, MOD.W, DIV.WU
// and MOD.WU. One quotient bit is produced per clock, so a divide occupies
// WIDTH iteration cycles. The result is then held (div_done high) until EX
// acknowledges it, so a stalled EX stage never restarts the operation.
//
// Ports:
//   clk         clock
//   resetn      synchronous, active-low reset
//   div_en      request; held by the initiator until div_ack
//   div_op      00 DIV.W, 01 MOD.W, 10 DIV.WU, 11 MOD.WU
//   src1        dividend
//   src2        divisor
//   div_ack     result consumed by EX (only meaningful while div_done)
//   div_cancel  flush; aborts any operation, highest priority
//   div_result  quotient or remainder, registered, retained across cancel
//   div_busy    iteration in progress
//   div_done    result valid; held until div_ack or div_cancel
// -----------------------------------------------------------------------------
module div_iter #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             div_en,
   input  logic [1:0]       div_op,
   input  logic [WIDTH-1:0] src1,
   input  logic [WIDTH-1:0] src2,
   input  logic             div_ack,
   input  logic             div_cancel,
   output logic [WIDTH-1:0] div_result,
   output logic             div_busy,
   output logic             div_done
);

   // Counter only has to reach WIDTH-1.
   localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
   localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ITER = 2'd1,
      DONE = 2'd2
   } state_t;

   state_t           state_reg;
   state_t           state_next;
   logic             busy_reg;
   logic             busy_next;
   logic             done_reg;
   logic             done_next;
   logic [CW-1:0]    count_reg;
   logic [WIDTH-1:0] rem_reg;       // partial remainder
   logic [WIDTH-1:0] quo_reg;       // dividend bits shift out, quotient bits shift in
   logic [WIDTH-1:0] divisor_reg;   // divisor magnitude
   logic [WIDTH-1:0] dividend_reg;  // raw dividend, returned by mod-by-zero
   logic             q_neg_reg;     // quotient must be negated at the end
   logic             r_neg_reg;     // remainder must be negated at the end
   logic             mod_reg;       // 1: return remainder, 0: return quotient
   logic             dz_reg;        // divisor was zero
   logic [WIDTH-1:0] result_reg;

   // ---------------------------------------------------------------------------
   // Operand conditioning at accept time
   // ---------------------------------------------------------------------------
   logic             is_signed;
   logic             neg1;
   logic             neg2;
   logic [WIDTH-1:0] mag1;
   logic [WIDTH-1:0] mag2;

   always_comb begin
      is_signed = ~div_op[1];
      neg1      = is_signed & src1[WIDTH-1];
      neg2      = is_signed & src2[WIDTH-1];
      // Two's-complement magnitude; 0x80..0 maps onto itself, which is the
      // correct unsigned magnitude and makes the overflow case fall out.
      mag1      = neg1 ? (~src1 + 1'b1) : src1;
      mag2      = neg2 ? (~src2 + 1'b1) : src2;
   end

   // ---------------------------------------------------------------------------
   // One restoring step
   // ---------------------------------------------------------------------------
   logic [WIDTH:0]   rem_shift;
   logic [WIDTH:0]   trial;
   logic [WIDTH-1:0] rem_step;
   logic [WIDTH-1:0] quo_step;

   always_comb begin
      // Shift remainder:dividend left by one; the extra top bit keeps the
      // trial subtraction from wrapping.
      rem_shift = {rem_reg, quo_reg[WIDTH-1]};
      trial     = rem_shift - {1'b0, divisor_reg};
      if (!trial[WIDTH]) begin
         rem_step = trial[WIDTH-1:0];
         quo_step = {quo_reg[WIDTH-2:0], 1'b1};
      end else begin
         rem_step = rem_shift[WIDTH-1:0];
         quo_step = {quo_reg[WIDTH-2:0], 1'b0};
      end
   end

   // ---------------------------------------------------------------------------
   // Sign fixup and result select, evaluated on the last step's outputs
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0] quo_fixed;
   logic [WIDTH-1:0] rem_fixed;
   logic [WIDTH-1:0] final_result;

   always_comb begin
      quo_fixed = q_neg_reg ? (~quo_step + 1'b1) : quo_step;
      rem_fixed = r_neg_reg ? (~rem_step + 1'b1) : rem_step;
      if (dz_reg) begin
         // Divide by zero bypasses the fixup entirely.
         final_result = mod_reg ? dividend_reg : {WIDTH{1'b1}};
      end else begin
         final_result = mod_reg ? rem_fixed : quo_fixed;
      end
   end

   // ---------------------------------------------------------------------------
   // Control
   // ---------------------------------------------------------------------------
   logic last_step;
   logic accept;
   logic step;

   assign last_step = (count_reg == LAST_STEP);
   assign accept    = (state_reg == IDLE) && div_en && !div_cancel;
   assign step      = (state_reg == ITER) && !div_cancel;

   always_ff @(posedge clk) begin
      if (!resetn) begin
         state_reg <= IDLE;
         busy_reg  <= 1'b0;
         done_reg  <= 1'b0;
      end else begin
         state_reg <= state_next;
         busy_reg  <= busy_next;
         done_reg  <= done_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      case (state_reg)
         IDLE:    if (div_en)    state_next = ITER;
         ITER:    if (last_step) state_next = DONE;
         DONE:    if (div_ack)   state_next = IDLE;
         default:                state_next = IDLE;
      endcase
      // Cancel overrides everything, including a request seen in IDLE.
      if (div_cancel) begin
         state_next = IDLE;
      end
      // Flags mirror the next state so they come straight from registers.
      busy_next = (state_next == ITER);
      done_next = (state_next == DONE);
   end

   // ---------------------------------------------------------------------------
   // Datapath
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!resetn) begin
         count_reg    <= '0;
         rem_reg      <= '0;
         quo_reg      <= '0;
         divisor_reg  <= '0;
         dividend_reg <= '0;
         q_neg_reg    <= 1'b0;
         r_neg_reg    <= 1'b0;
         mod_reg      <= 1'b0;
         dz_reg       <= 1'b0;
         result_reg   <= '0;
      end else if (accept) begin
         count_reg    <= '0;
         rem_reg      <= '0;
         quo_reg      <= mag1;
         divisor_reg  <= mag2;
         dividend_reg <= src1;
         q_neg_reg    <= neg1 ^ neg2;
         r_neg_reg    <= neg1;
         mod_reg      <= div_op[0];
         dz_reg       <= (src2 == '0);
      end else if (step) begin
         rem_reg   <= rem_step;
         quo_reg   <= quo_step;
         count_reg <= count_reg + 1'b1;
         if (last_step) begin
            result_reg <= final_result;
         end
      end
   end

   assign div_result = result_reg;
   assign div_busy   = busy_reg;
   assign div_done   = done_reg;

endmodule

// File: tb/tb_div_iter.sv
// -----------------------------------------------------------------------------
// tb_div_iter -- directed and randomised checks for div_iter (WIDTH = 32)
//
// Inputs change on the falling edge, outputs are sampled on the falling edge,
// so every observation is half a cycle away from the active rising edge.
// -----------------------------------------------------------------------------
module tb_div_iter;

   localparam int W   = 32;
   localparam int LAT = W + 1;  // falling edges from accept to first done

   logic         clk;
   logic         resetn;
   logic         div_en;
   logic [1:0]   div_op;
   logic [W-1:0] src1;
   logic [W-1:0] src2;
   logic         div_ack;
   logic         div_cancel;
   logic [W-1:0] div_result;
   logic         div_busy;
   logic         div_done;

   int checks = 0;
   int errors = 0;

   div_iter #(.WIDTH(W)) dut (
      .clk        (clk),
      .resetn     (resetn),
      .div_en     (div_en),
      .div_op     (div_op),
      .src1       (src1),
      .src2       (src2),
      .div_ack    (div_ack),
      .div_cancel (div_cancel),
      .div_result (div_result),
      .div_busy   (div_busy),
      .div_done   (div_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Reference: LoongArch divide semantics written directly from the ISA rules.
   function automatic logic [W-1:0] ref_div(input logic [1:0] op,
                                            input logic [W-1:0] a,
                                            input logic [W-1:0] b);
      logic signed [W-1:0] sa;
      logic signed [W-1:0] sb;
      sa = a;
      sb = b;
      if (b == 0) return op[0] ? a : 32'hFFFF_FFFF;
      if (!op[1]) begin
         if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF)
            return op[0] ? 32'h0 : 32'h8000_0000;
         return op[0] ? W'(sa % sb) : W'(sa / sb);
      end
      return op[0] ? (a % b) : (a / b);
   endfunction

   function automatic logic [W-1:0] pick_val();
      case ($urandom_range(0, 7))
         0:       return 32'h0;
         1:       return 32'h8000_0000;
         2:       return 32'hFFFF_FFFF;
         3:       return W'($urandom_range(0, 20));
         4:       return 32'h0 - W'($urandom_range(1, 20));
         default: return $urandom;
      endcase
   endfunction

   // Present a request on a falling edge; returns just after the accept edge.
   task automatic issue(input logic [1:0] op, input logic [W-1:0] a, input logic [W-1:0] b);
      @(negedge clk);
      div_en = 1'b1;
      div_op = op;
      src1   = a;
      src2   = b;
      @(posedge clk);
   endtask

   // Walk falling edges until done (bounded); optionally scramble operands.
   task automatic wait_done(output int lat, output int busy_n, input bit toggle);
      lat    = 0;
      busy_n = 0;
      do begin
         @(negedge clk);
         lat++;
         if (div_busy) busy_n++;
         if (toggle && !div_done) begin
            src1 = $urandom;
            src2 = $urandom;
         end
      end while (!div_done && lat < 100);
   endtask

   // Consume the result: one-cycle ack with the request dropped.
   task automatic release_result();
      div_ack = 1'b1;
      div_en  = 1'b0;
      @(negedge clk);
      div_ack = 1'b0;
   endtask

   task automatic test_reset();
      resetn = 1'b0;
      repeat (2) @(negedge clk);
      checks++;
      if (div_busy !== 1'b0) begin
         errors++;
         $display("FAIL reset_busy: got %b want 0", div_busy);
      end
      checks++;
      if (div_done !== 1'b0) begin
         errors++;
         $display("FAIL reset_done: got %b want 0", div_done);
      end
      checks++;
      if (div_result !== 32'h0) begin
         errors++;
         $display("FAIL reset_result: got %h want 00000000", div_result);
      end
      resetn = 1'b1;
      @(negedge clk);
      $display("reset: busy=%b done=%b result=%h", div_busy, div_done, div_result);
   endtask

   task automatic test_basic();
      int lat;
      int busy_n;
      div_ack = 1'b1;
      issue(2'b00, 32'd7, 32'd2);
      wait_done(lat, busy_n, 1'b0);
      checks++;
      if (lat !== LAT) begin
         errors++;
         $display("FAIL basic_latency: got %0d want %0d", lat, LAT);
      end
      checks++;
      if (busy_n !== W) begin
         errors++;
         $display("FAIL basic_busy_cycles: got %0d want %0d", busy_n, W);
      end
      checks++;
      if (div_result !== 32'd3) begin
         errors++;
         $display("FAIL basic_result: got %h want 00000003", div_result);
      end
      div_en = 1'b0;
      @(negedge clk);
      checks++;
      if (div_done !== 1'b0 || div_busy !== 1'b0) begin
         errors++;
         $display("FAIL basic_done_drop: got done=%b busy=%b want 0 0", div_done, div_busy);
      end
      div_ack = 1'b0;
      $display("DIV.W 7/2: result=%h latency=%0d busy=%0d", div_result, lat, busy_n);
   endtask

   task automatic test_signed_and_corners();
      logic [1:0]   op_t  [8] = '{2'b01, 2'b00, 2'b10, 2'b11, 2'b00, 2'b01, 2'b10, 2'b01};
      logic [W-1:0] a_t   [8] = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9,
                                  32'h8000_0000, 32'h8000_0000, 32'd5, 32'hFFFF_FFFB};
      logic [W-1:0] b_t   [8] = '{32'd2, 32'd2, 32'd2, 32'd2,
                                  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
      logic [W-1:0] exp_t [8] = '{32'hFFFF_FFFF, 32'hFFFF_FFFD, 32'h7FFF_FFFC, 32'h1,
                                  32'h8000_0000, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFB};
      int lat;
      int busy_n;
      for (int i = 0; i < 8; i++) begin
         issue(op_t[i], a_t[i], b_t[i]);
         wait_done(lat, busy_n, 1'b0);
         checks++;
         if (div_result !== exp_t[i] || lat !== LAT) begin
            errors++;
            $display("FAIL vector_%0d: got %h lat %0d want %h lat %0d",
                     i, div_result, lat, exp_t[i], LAT);
         end
         $display("op=%b a=%h b=%h result=%h latency=%0d", op_t[i], a_t[i], b_t[i], div_result, lat);
         release_result();
      end
   endtask

   task automatic test_stall();
      int lat;
      int busy_n;
      issue(2'b10, 32'd100, 32'd7);
      wait_done(lat, busy_n, 1'b0);
      checks++;
      if (div_result !== 32'd14 || lat !== LAT) begin
         errors++;
         $display("FAIL stall_first: got %h lat %0d want 0000000e lat %0d", div_result, lat, LAT);
      end
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         checks++;
         if (div_done !== 1'b1 || div_busy !== 1'b0 || div_result !== 32'd14) begin
            errors++;
            $display("FAIL stall_hold_%0d: got done=%b busy=%b result=%h want 1 0 0000000e",
                     i, div_done, div_busy, div_result);
         end
      end
      div_ack = 1'b1;  // div_en stays high
      @(negedge clk);
      div_ack = 1'b0;
      checks++;
      if (div_done !== 1'b0 || div_busy !== 1'b0) begin
         errors++;
         $display("FAIL stall_ack_idle: got done=%b busy=%b want 0 0", div_done, div_busy);
      end
      @(negedge clk);
      checks++;
      if (div_busy !== 1'b1) begin
         errors++;
         $display("FAIL stall_reaccept: got busy=%b want 1", div_busy);
      end
      wait_done(lat, busy_n, 1'b0);
      checks++;
      if (div_result !== 32'd14 || lat !== LAT - 1) begin
         errors++;
         $display("FAIL stall_second: got %h lat %0d want 0000000e lat %0d", div_result, lat, LAT - 1);
      end
      $display("DIV.WU 100/7 stalled: result=%h", div_result);
      release_result();
   endtask

   task automatic test_cancel();
      int lat;
      int busy_n;
      issue(2'b00, 32'd1000, 32'd3);
      repeat (10) @(negedge clk);
      checks++;
      if (div_busy !== 1'b1) begin
         errors++;
         $display("FAIL cancel_pre_busy: got %b want 1", div_busy);
      end
      div_cancel = 1'b1;  // request still high: must not be taken
      @(negedge clk);
      checks++;
      if (div_busy !== 1'b0 || div_done !== 1'b0 || div_result !== 32'd14) begin
         errors++;
         $display("FAIL cancel_abort: got busy=%b done=%b result=%h want 0 0 0000000e",
                  div_busy, div_done, div_result);
      end
      div_cancel = 1'b0;
      div_en     = 1'b0;
      @(negedge clk);
      issue(2'b00, 32'd9, 32'd3);
      wait_done(lat, busy_n, 1'b0);
      checks++;
      if (div_result !== 32'd3 || lat !== LAT) begin
         errors++;
         $display("FAIL cancel_next: got %h lat %0d want 00000003 lat %0d", div_result, lat, LAT);
      end
      $display("cancel then DIV.W 9/3: result=%h latency=%0d", div_result, lat);
      release_result();
   endtask

   task automatic test_reset_mid();
      int lat;
      int busy_n;
      issue(2'b00, 32'd100, 32'd3);
      repeat (5) @(negedge clk);
      resetn = 1'b0;
      @(negedge clk);
      checks++;
      if (div_busy !== 1'b0 || div_done !== 1'b0 || div_result !== 32'h0) begin
         errors++;
         $display("FAIL reset_iter: got busy=%b done=%b result=%h want 0 0 00000000",
                  div_busy, div_done, div_result);
      end
      resetn = 1'b1;
      div_en = 1'b0;
      issue(2'b00, 32'd9, 32'd3);
      wait_done(lat, busy_n, 1'b0);
      checks++;
      if (div_result !== 32'd3) begin
         errors++;
         $display("FAIL reset_pre_done: got %h want 00000003", div_result);
      end
      resetn = 1'b0;
      @(negedge clk);
      checks++;
      if (div_busy !== 1'b0 || div_done !== 1'b0 || div_result !== 32'h0) begin
         errors++;
         $display("FAIL reset_done_state: got busy=%b done=%b result=%h want 0 0 00000000",
                  div_busy, div_done, div_result);
      end
      resetn = 1'b1;
      div_en = 1'b0;
      @(negedge clk);
      $display("reset mid-operation: busy=%b done=%b result=%h", div_busy, div_done, div_result);
   endtask

   task automatic test_random();
      int           lat;
      int           busy_n;
      logic [1:0]   op;
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W-1:0] exp;
      for (int n = 0; n < 1000; n++) begin
         op  = 2'($urandom_range(0, 3));
         a   = pick_val();
         b   = pick_val();
         exp = ref_div(op, a, b);
         issue(op, a, b);
         wait_done(lat, busy_n, 1'b1);
         checks++;
         if (div_result !== exp || lat !== LAT) begin
            errors++;
            $display("FAIL random_%0d: op=%b a=%h b=%h got %h lat %0d want %h lat %0d",
                     n, op, a, b, div_result, lat, exp, LAT);
         end else begin
            $display("rand %0d: op=%b a=%h b=%h result=%h", n, op, a, b, div_result);
         end
         release_result();
      end
   endtask

   initial begin
      resetn     = 1'b0;
      div_en     = 1'b0;
      div_op     = 2'b00;
      src1       = '0;
      src2       = '0;
      div_ack    = 1'b0;
      div_cancel = 1'b0;
      test_reset();
      test_basic();
      test_signed_and_corners();
      test_stall();
      test_cancel();
      test_reset_mid();
      test_random();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
